// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command framer and its byte port.
package uart_cmd_pkg;
  localparam int         FRAME_LEN    = 5;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_DEFAULT  = 8'h06;
  localparam logic [7:0] NAK_DEFAULT  = 8'h15;

  typedef enum logic [2:0] {F_HUNT, F_OP, F_AHI, F_ALO, F_CSUM, F_DISPATCH} frame_st_e;
  typedef enum logic [2:0] {P_IDLE, P_RD, P_DRAIN, P_WR, P_GAP} port_st_e;

  function automatic logic [7:0] frame_csum(input logic [7:0] op, input logic [7:0] hi,
                                            input logic [7:0] lo);
    return op ^ hi ^ lo;
  endfunction
endpackage

// File: rtl/uart_byte_port.sv
// COREUART strobe sequencer: one-cycle read/write accesses, RXRDY drain, post-write gap.
module uart_byte_port import uart_cmd_pkg::*; #(
  parameter int TX_GAP = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rd_req_i,
  input  logic       wr_req_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_gnt_o,
  output logic       rd_vld_o,
  output logic [7:0] rd_data_o,
  output logic       rd_err_o,
  output logic       csn_o,
  output logic       oen_o,
  output logic       wen_o,
  output logic [7:0] data_in_o,
  input  logic [7:0] data_out_i,
  input  logic       rxrdy_i,
  input  logic       txrdy_i,
  input  logic       perr_i,
  input  logic       ferr_i
);
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  port_st_e   st_q;
  logic [GW-1:0] gap_q;
  logic       csn_q, oen_q, wen_q, rvld_q, rerr_q;
  logic [7:0] din_q, rdata_q;
  logic       rd_gnt;

  // Reads win over writes so the UART RX holding register is emptied first.
  assign rd_gnt   = (st_q == P_IDLE) && rd_req_i && rxrdy_i;
  assign wr_gnt_o = (st_q == P_IDLE) && !rd_gnt && wr_req_i && txrdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= P_IDLE;
      gap_q   <= '0;
      csn_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      din_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      rvld_q <= 1'b0;
      csn_q  <= 1'b1;
      oen_q  <= 1'b1;
      wen_q  <= 1'b1;
      case (st_q)
        P_IDLE: begin
          if (rd_gnt) begin
            st_q  <= P_RD;
            csn_q <= 1'b0;
            oen_q <= 1'b0;
          end else if (wr_gnt_o) begin
            st_q  <= P_WR;
            csn_q <= 1'b0;
            wen_q <= 1'b0;
            din_q <= wr_data_i;
          end
        end
        P_RD: begin
          rdata_q <= data_out_i;
          rerr_q  <= perr_i | ferr_i;
          rvld_q  <= 1'b1;
          st_q    <= P_DRAIN;
        end
        P_DRAIN: if (!rxrdy_i) st_q <= P_IDLE;
        P_WR: begin
          gap_q <= '0;
          st_q  <= P_GAP;
        end
        P_GAP: begin
          if (gap_q == GW'(TX_GAP - 1)) st_q <= P_IDLE;
          else gap_q <= gap_q + 1'b1;
        end
        default: st_q <= P_IDLE;
      endcase
    end
  end

  assign csn_o     = csn_q;
  assign oen_o     = oen_q;
  assign wen_o     = wen_q;
  assign data_in_o = din_q;
  assign rd_vld_o  = rvld_q;
  assign rd_data_o = rdata_q;
  assign rd_err_o  = rerr_q;
endmodule

// File: rtl/uart_cmd_framer.sv
// Hunts framed 5-byte commands from the UART, checks them, presents them on a
// valid/ready port and replies ACK/NAK + opcode through the UART TX side.
module uart_cmd_framer import uart_cmd_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         TIMEOUT_W      = 16,
  parameter int         TX_GAP         = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        UART_CSN,
  output logic        UART_OEN,
  output logic        UART_WEN,
  output logic [7:0]  UART_DATA_IN,
  input  logic [7:0]  UART_DATA_OUT,
  input  logic        UART_RXRDY,
  input  logic        UART_TXRDY,
  input  logic        UART_PARITY_ERR,
  input  logic        UART_FRAMING_ERR,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic [7:0]  CMD_OP,
  output logic [15:0] CMD_ARG,
  output logic [7:0]  FRAME_ERR_CNT,
  output logic        BUSY
);
  frame_st_e           fs_q;
  logic [7:0]          op_q, ahi_q, alo_q, err_cnt_q;
  logic                cmd_vld_q;
  logic [1:0][7:0]     rq_q;
  logic [1:0]          rq_cnt_q;
  logic [TIMEOUT_W-1:0] to_q;

  logic       rd_vld, rd_err, wr_gnt, rd_req, pend, in_frame, timeout, push, bad;
  logic [7:0] rd_data, push_st, push_op;

  assign pend     = (rq_cnt_q != 2'd0);
  assign in_frame = fs_q inside {F_OP, F_AHI, F_ALO, F_CSUM};
  assign rd_req   = in_frame || ((fs_q == F_HUNT) && !pend);
  // Only byte-waiting states time out; a slow consumer in DISPATCH never drops a command.
  assign timeout  = in_frame && !rd_vld && (to_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    push    = 1'b0;
    bad     = 1'b0;
    push_st = NAK_BYTE;
    push_op = op_q;
    if (rd_vld && in_frame) begin
      if (rd_err) begin
        push = 1'b1;
        bad  = 1'b1;
        if (fs_q == F_OP) push_op = 8'h00;
      end else if (fs_q == F_CSUM && rd_data != frame_csum(op_q, ahi_q, alo_q)) begin
        push = 1'b1;
        bad  = 1'b1;
      end
    end
    if (fs_q == F_DISPATCH && CMD_READY) begin
      push    = 1'b1;
      push_st = ACK_BYTE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fs_q      <= F_HUNT;
      op_q      <= '0;
      ahi_q     <= '0;
      alo_q     <= '0;
      err_cnt_q <= '0;
      cmd_vld_q <= 1'b0;
      rq_q      <= '0;
      rq_cnt_q  <= '0;
      to_q      <= '0;
    end else begin
      to_q <= (rd_vld || !in_frame) ? '0 : to_q + 1'b1;
      // push only happens with the queue empty, so it never collides with a pop
      if (push) begin
        rq_q     <= {push_op, push_st};
        rq_cnt_q <= 2'd2;
      end else if (wr_gnt) begin
        rq_q[0]  <= rq_q[1];
        rq_cnt_q <= rq_cnt_q - 1'b1;
      end
      if ((bad || timeout) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
      if (bad || timeout) fs_q <= F_HUNT;
      else begin
        case (fs_q)
          F_HUNT:  if (rd_vld && !rd_err && rd_data == SYNC_BYTE) fs_q <= F_OP;
          F_OP:    if (rd_vld) begin op_q  <= rd_data; fs_q <= F_AHI; end
          F_AHI:   if (rd_vld) begin ahi_q <= rd_data; fs_q <= F_ALO; end
          F_ALO:   if (rd_vld) begin alo_q <= rd_data; fs_q <= F_CSUM; end
          F_CSUM:  if (rd_vld) begin cmd_vld_q <= 1'b1; fs_q <= F_DISPATCH; end
          F_DISPATCH: if (CMD_READY) begin cmd_vld_q <= 1'b0; fs_q <= F_HUNT; end
          default: fs_q <= F_HUNT;
        endcase
      end
    end
  end

  uart_byte_port #(.TX_GAP(TX_GAP)) u_port (
    .clk_i(CLK), .rst_i(RESET),
    .rd_req_i(rd_req), .wr_req_i(pend), .wr_data_i(rq_q[0]), .wr_gnt_o(wr_gnt),
    .rd_vld_o(rd_vld), .rd_data_o(rd_data), .rd_err_o(rd_err),
    .csn_o(UART_CSN), .oen_o(UART_OEN), .wen_o(UART_WEN), .data_in_o(UART_DATA_IN),
    .data_out_i(UART_DATA_OUT), .rxrdy_i(UART_RXRDY), .txrdy_i(UART_TXRDY),
    .perr_i(UART_PARITY_ERR), .ferr_i(UART_FRAMING_ERR)
  );

  assign CMD_VALID     = cmd_vld_q;
  assign CMD_OP        = op_q;
  assign CMD_ARG       = {ahi_q, alo_q};
  assign FRAME_ERR_CNT = err_cnt_q;
  assign BUSY          = (fs_q != F_HUNT) || pend;
endmodule
